mult8x8_exact: RTL and testbench
================================

// Module: mult8x8_exact
// PURPOSE
//   Exact unsigned 8x8 -> 16-bit multiplier. This is the accurate baseline
//   against which the approximate multiplier variants are compared.
//   - Combinational product output, P = A*B, with no truncation or approximation.
//   - Registered copy of the same product for clocked datapaths.
//   - Drop-in for any arithmetic unit that needs a full-precision 8-bit product.
// PARAMETERS
//   None. Widths are fixed: 8-bit operands, 16-bit product.
// PORTS
//   clk    in   1   system clock; rising edge active
//   rst    in   1   asynchronous, active-high reset
//   A      in   8   multiplicand, unsigned
//   B      in   8   multiplier, unsigned
//   P      out  16  combinational product A*B, exact
//   P_q    out  16  registered product (P sampled on clk rising edge)
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-high.
//   - P is purely combinational from A and B.
//     - Zero-cycle latency; no dependence on clk or rst.
//     - Settles within the same delta/timestep as an input change.
//   - P == {8'b0,A} * {8'b0,B} for all 65536 input pairs.
//     - Unsigned only.
//     - Maximum value is 255*255 = 16'hFE01 (65025), so no overflow is possible.
//   - P_q
//     - On rst asserted: P_q = 16'h0000 immediately, with no clock required.
//     - While rst is high: P_q holds 0.
//     - After rst deasserts: each rising clk edge loads P_q <= P.
//     - Latency is 1 cycle.
//   - Reset mid-operation: P is unaffected. P_q clears at once and resumes
//     tracking on the first clk edge after deassertion.
//   - X/Z on A or B may propagate to P. There is no internal state other
//     than P_q.
//   - Implementation must not use the behavioural '*' operator. Build an
//     explicit array multiplier:
//     - 64 partial products pp[i][j] = A[j] & B[i].
//     - 7 rows of carry-save/ripple accumulation built from full/half adders.
//     - A final ripple stage forms P[15:8]; P[0] = pp[0][0].
// STRUCTURE
//   - Sub-module fa_cell(a, b, cin -> s, cout).
//     - Single-bit full adder.
//     - A half adder is fa_cell with cin tied to 0.
//   - Top level:
//     - AND array for the partial products.
//     - Generate loops instantiating the fa_cell array (row x column).
//     - Output register for P_q.
//   - Shared package: OP_W = 8 and PROD_W = 16 localparams, reused by the
//     approximate variants and their benches. No typedefs are needed.
// TESTING
//   Combinational checks compare P after #1 settle; P_q is checked one clk
//   edge later.
//   1. Corner operands:
//      - A=0, B=0 -> P=0
//      - A=255, B=1 -> P=255
//      - A=128, B=128 -> P=16384
//      - A=255, B=255 -> P=65025
//   2. Mid-range operands:
//      - A=12, B=15 -> P=180
//      - A=100, B=200 -> P=20000
//      - A=50, B=5 -> P=250
//   3. Random sweep:
//      - Apply >= 1000 $random pairs; P == A*B (golden '*' model in the bench).
//      - Also run an exhaustive 65536-pair loop; zero mismatches required.
//   4. Register path:
//      - Apply A=100, B=200; one clk edge later P_q=20000.
//      - Change to A=3, B=7: P_q keeps 20000 until the next edge, then becomes 21.
//   5. Async reset:
//      - With P_q=21, assert rst between clk edges -> P_q=0 immediately,
//        while P still reads 21.
//      - Deassert rst -> P_q=21 after the next edge.

Source files
------------

// File: rtl/mult8x8_exact_pkg.sv
// Shared widths for the exact and approximate
// 8x8 multiplier family.
package mult8x8_exact_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
endpackage

// File: rtl/mult8x8_exact_fa_cell.sv
// Single-bit full adder; tie cin low for
// a half adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mult8x8_exact.sv
// Exact unsigned 8x8 array multiplier with
// combinational and registered product.
module mult8x8_exact
  import mult8x8_exact_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] P,
  output logic [PROD_W-1:0] P_q
);
  logic [OP_W-1:0][OP_W-1:0] pp;
  logic [OP_W-1:0][OP_W:0]   acc;
  logic [OP_W-1:0][OP_W:0]   cy;
  logic [PROD_W-1:0]         prod_d;

  genvar i, j;
  generate
    for (i = 0; i < OP_W; i++) begin : g_pp
      for (j = 0; j < OP_W; j++) begin : g_bit
        assign pp[i][j] = A[j] & B[i];
      end
    end
  endgenerate

  assign acc[0] = {1'b0, pp[0]};
  assign cy[0]  = '0;

  // Row i adds pp[i] to the previous row shifted
  // right by one; bit 0 of each row is final.
  generate
    for (i = 1; i < OP_W; i++) begin : g_row
      assign cy[i][0] = 1'b0;
      for (j = 0; j < OP_W; j++) begin : g_col
        fa_cell u_fa (
          .a    (pp[i][j]),
          .b    (acc[i-1][j+1]),
          .cin  (cy[i][j]),
          .s    (acc[i][j]),
          .cout (cy[i][j+1])
        );
      end
      assign acc[i][OP_W] = cy[i][OP_W];
    end
  endgenerate

  generate
    for (i = 0; i < OP_W; i++) begin : g_lo
      assign P[i] = acc[i][0];
    end
  endgenerate

  assign P[PROD_W-1:OP_W] = acc[OP_W-1][OP_W:1];
  assign prod_d = P;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) P_q <= '0;
    else     P_q <= prod_d;
  end
endmodule

// File: tb/tb_mult8x8_exact.sv
// Directed and sweep checks for the exact
// 8x8 multiplier and its output register.
module tb_mult8x8_exact;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [15:0] P;
  logic [15:0] P_q;
  int total = 0;
  int bad   = 0;

  mult8x8_exact dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .P   (P),
    .P_q (P_q)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    A = 8'd9;
    B = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (P_q !== 16'h0000) begin
      bad++;
      $display("FAIL reset_hold P_q=%h want=0000", P_q);
    end
    total++;
    if (P !== 16'd81) begin
      bad++;
      $display("FAIL reset_comb P=%0d want=81", P);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_corners();
    logic [7:0]  av [4] = '{0, 255, 128, 255};
    logic [7:0]  bv [4] = '{0, 1, 128, 255};
    logic [15:0] ev [4] = '{0, 255, 16384, 65025};
    for (int k = 0; k < 4; k++) begin
      A = av[k];
      B = bv[k];
      #1;
      total++;
      if (P !== ev[k]) begin
        bad++;
        $display("FAIL corner%0d P=%0d want=%0d",
                 k, P, ev[k]);
      end
    end
  endtask

  task automatic test_mid();
    logic [7:0]  av [3] = '{12, 100, 50};
    logic [7:0]  bv [3] = '{15, 200, 5};
    logic [15:0] ev [3] = '{180, 20000, 250};
    for (int k = 0; k < 3; k++) begin
      A = av[k];
      B = bv[k];
      #1;
      total++;
      if (P !== ev[k]) begin
        bad++;
        $display("FAIL mid%0d P=%0d want=%0d",
                 k, P, ev[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_p;
    for (int k = 0; k < 1200; k++) begin
      A = 8'($random);
      B = 8'($random);
      exp_p = {8'b0, A} * {8'b0, B};
      #1;
      total++;
      if (P !== exp_p) begin
        bad++;
        $display("FAIL random A=%0d B=%0d P=%0d want=%0d",
                 A, B, P, exp_p);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [15:0] exp_p;
    int miss = 0;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        A = 8'(a);
        B = 8'(b);
        exp_p = 16'(a * b);
        #1;
        total++;
        if (P !== exp_p) begin
          bad++;
          if (miss < 10)
            $display("FAIL exh A=%0d B=%0d P=%0d want=%0d",
                     a, b, P, exp_p);
          miss++;
        end
      end
    end
  endtask

  task automatic test_register();
    @(negedge clk);
    A = 8'd100;
    B = 8'd200;
    @(posedge clk);
    #1;
    total++;
    if (P_q !== 16'd20000) begin
      bad++;
      $display("FAIL reg_load P_q=%0d want=20000", P_q);
    end
    @(negedge clk);
    A = 8'd3;
    B = 8'd7;
    #1;
    total++;
    if (P_q !== 16'd20000) begin
      bad++;
      $display("FAIL reg_hold P_q=%0d want=20000", P_q);
    end
    @(posedge clk);
    #1;
    total++;
    if (P_q !== 16'd21) begin
      bad++;
      $display("FAIL reg_next P_q=%0d want=21", P_q);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (P_q !== 16'h0000) begin
      bad++;
      $display("FAIL async_clr P_q=%0d want=0", P_q);
    end
    total++;
    if (P !== 16'd21) begin
      bad++;
      $display("FAIL async_comb P=%0d want=21", P);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (P_q !== 16'h0000) begin
      bad++;
      $display("FAIL async_pre P_q=%0d want=0", P_q);
    end
    @(posedge clk);
    #1;
    total++;
    if (P_q !== 16'd21) begin
      bad++;
      $display("FAIL async_resume P_q=%0d want=21", P_q);
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_mid();
    test_random();
    test_exhaustive();
    test_register();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
